// File: rtl/hist_pkg.sv
// Shared definitions for the histogram bin memory.
// Holds the default widths, the clear FSM state encoding and the saturating
// increment used by the read-modify-write pipeline.
package hist_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 20;

  // Working width of sat_inc; counters up to this width are supported.
  localparam int unsigned SAT_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  // Returns value+1, or limit when value has already reached limit.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] limit);
    if (value >= limit) begin
      return limit;
    end
    return value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/histogram_ram_if.sv
// Bus bundle of the histogram bin memory.
//   inc_valid/inc_addr : increment request for one bin
//   rd_en/rd_addr      : read request, answered by rd_valid/rd_data one cycle later
//   clr_start          : request a full clear sweep
//   clr_busy/clr_done  : sweep running / one-cycle completion pulse
//   overflow           : sticky saturation flag
// master = pixel source / CDF stage, slave = histogram_ram.
interface histogram_ram_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 20
) ();

  logic                  inc_valid;
  logic [ADDR_WIDTH-1:0] inc_addr;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  clr_start;
  logic                  clr_busy;
  logic                  clr_done;
  logic                  overflow;

  modport master (
    output inc_valid, inc_addr, rd_en, rd_addr, clr_start,
    input  rd_data, rd_valid, clr_busy, clr_done, overflow
  );

  modport slave (
    input  inc_valid, inc_addr, rd_en, rd_addr, clr_start,
    output rd_data, rd_valid, clr_busy, clr_done, overflow
  );

endinterface

// File: rtl/ram_1w2r.sv
// One-write, two-read synchronous RAM built from two simple dual-port copies
// that share the write port. Port A feeds the increment pipeline, port B the
// user read. Reads are read-first: a read of the address being written in the
// same cycle returns the old contents. No reset; contents persist.
//   we/waddr/wdata : shared write port
//   re_a/raddr_a   : read port A, rdata_a valid the cycle after re_a
//   re_b/raddr_b   : read port B, rdata_b valid the cycle after re_b
module ram_1w2r #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re_a,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic          re_b,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  // Copy A: shared write, increment-path read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_a[waddr] <= wdata;
    end
    if (re_a) begin
      rdata_a <= mem_a[raddr_a];
    end
  end

  // Copy B: shared write, user read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_b[waddr] <= wdata;
    end
    if (re_b) begin
      rdata_b <= mem_b[raddr_b];
    end
  end

endmodule

// File: rtl/histogram_ram.sv
// Histogram bin memory: counts occurrences per bin with a two-stage
// read-modify-write pipeline, serves counts on an independent read port and
// clears all bins with a hardware sweep.
//   clk   : sole clock
//   rst_n : asynchronous active-low reset (bin contents are not reset)
//   bus   : histogram_ram_if slave (increment, read, clear, overflow)
module histogram_ram
  import hist_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned C_DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter bit          C_CLEAR_ON_RESET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  histogram_ram_if.slave bus
);

  localparam int unsigned AW = C_ADDR_WIDTH;
  localparam int unsigned DW = C_DATA_WIDTH;

  localparam logic [DW-1:0] CNT_MAX  = '1;
  localparam logic [AW-1:0] LAST_BIN = '1;

  // Clear FSM
  clr_state_e    state;
  clr_state_e    state_nxt;
  logic [AW-1:0] clr_cnt;
  logic          auto_clr;
  logic          clr_accept;
  logic          sweep_last;
  logic          clr_done_q;

  // Increment pipeline
  logic          inc_acc;
  logic          s2_valid;
  logic [AW-1:0] s2_addr;
  logic          fwd_sel;
  logic [DW-1:0] fwd_data;
  logic [DW-1:0] ram_inc_q;
  logic [DW-1:0] base;
  logic [DW-1:0] sum;
  logic          sat_hit;
  logic          overflow_q;

  // Shared write port
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  // User read
  logic [DW-1:0] ram_rd_q;
  logic          rd_valid_q;
  logic          rd_from_mem;

  ram_1w2r #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re_a    (inc_acc),
    .raddr_a (bus.inc_addr),
    .rdata_a (ram_inc_q),
    .re_b    (bus.rd_en),
    .raddr_b (bus.rd_addr),
    .rdata_b (ram_rd_q)
  );

  // Increments are dropped while sweeping and in the cycle a clear is accepted.
  assign inc_acc = bus.inc_valid && (state == IDLE) && !clr_accept;

  // Back-to-back hits on one bin: memory still holds the pre-write value, so
  // the S2 sum from the previous cycle is used instead.
  assign base    = fwd_sel ? fwd_data : ram_inc_q;
  assign sat_hit = (base == CNT_MAX);
  assign sum     = DW'(sat_inc(SAT_W'(base), SAT_W'(CNT_MAX)));

  // Clear FSM next state and write-port steering.
  always_comb begin
    state_nxt  = state;
    clr_accept = 1'b0;
    sweep_last = 1'b0;
    we         = s2_valid;
    waddr      = s2_addr;
    wdata      = sum;
    case (state)
      IDLE: begin
        if (bus.clr_start || auto_clr) begin
          clr_accept = 1'b1;
          state_nxt  = SWEEP;
        end
      end
      SWEEP: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = '0;
        if (clr_cnt == LAST_BIN) begin
          sweep_last = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear FSM state, sweep address, completion pulse and post-reset request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      auto_clr   <= C_CLEAR_ON_RESET;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      auto_clr   <= 1'b0;
      clr_done_q <= sweep_last;
      if (state == SWEEP) begin
        clr_cnt <= AW'(clr_cnt + 1'b1);
      end else begin
        clr_cnt <= '0;
      end
    end
  end

  // Increment pipeline S1 -> S2 registers and forwarding capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      fwd_sel  <= 1'b0;
      fwd_data <= '0;
    end else begin
      s2_valid <= inc_acc;
      if (inc_acc) begin
        s2_addr <= bus.inc_addr;
      end
      fwd_sel  <= inc_acc && s2_valid && (s2_addr == bus.inc_addr);
      fwd_data <= sum;
    end
  end

  // Sticky overflow; an accepted clear wins over a same-cycle saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (clr_accept) begin
      overflow_q <= 1'b0;
    end else if (s2_valid && sat_hit) begin
      overflow_q <= 1'b1;
    end
  end

  // Read response; reads issued during a sweep return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q  <= 1'b0;
      rd_from_mem <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_from_mem <= (state != SWEEP);
      end
    end
  end

  assign bus.rd_data  = rd_from_mem ? ram_rd_q : '0;
  assign bus.rd_valid = rd_valid_q;
  assign bus.clr_busy = (state == SWEEP);
  assign bus.clr_done = clr_done_q;
  assign bus.overflow = overflow_q;

endmodule
